// File: rtl/gmsk_pkg.sv
// Shared GMSK processor definitions: timer state encoding, timer mode
// constants and default timer widths.
package gmsk_pkg;

  localparam int TIMER_WIDTH = 4;
  localparam int TIMER_PRE_W = 4;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } timer_state_e;

endpackage

// File: rtl/timer_ctrl_if.sv
// Command/status bundle between a controller and timer_ctrl.
interface timer_ctrl_if
  import gmsk_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH,
  parameter int PRE_W = TIMER_PRE_W
);
  logic             start;
  logic             stop;
  logic             hold;
  logic             mode;
  logic [WIDTH-1:0] period;
  logic [PRE_W-1:0] prescale;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             expire;

  modport master (
    output start, stop, hold, mode, period, prescale,
    input  count, busy, done, expire
  );

  modport slave (
    input  start, stop, hold, mode, period, prescale,
    output count, busy, done, expire
  );
endinterface

// File: rtl/timer_ctrl_up_counter_en.sv
// W-bit up-counter with synchronous clear (wins over enable) and a
// compare-against-terminal output.
module up_counter_en #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         at_term
);
  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt     = cnt_q;
  assign at_term = (cnt_q == term);
endmodule

// File: rtl/timer_ctrl.sv
// Programmable timer: prescaled up-counter with one-shot/periodic modes,
// start/stop/hold sequencing and a registered one-cycle expire pulse.
module timer_ctrl
  import gmsk_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH,
  parameter int PRE_W = TIMER_PRE_W
) (
  input  logic         clk,
  input  logic         rst,
  timer_ctrl_if.slave  bus
);
  timer_state_e     state_d, state_q;
  logic [WIDTH-1:0] period_d, period_q;
  logic [PRE_W-1:0] prescale_d, prescale_q;
  logic             mode_d, mode_q;
  logic             expire_d, expire_q;

  logic             tick;
  logic             cnt_clr, cnt_en, cnt_term;
  logic             pre_clr, pre_en, pre_term;
  logic [WIDTH-1:0] count;
  logic [PRE_W-1:0] pre_cnt_unused;

  up_counter_en #(.W(WIDTH)) u_count (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .term    (period_q),
    .cnt     (count),
    .at_term (cnt_term)
  );

  up_counter_en #(.W(PRE_W)) u_prescale (
    .clk     (clk),
    .rst     (rst),
    .clr     (pre_clr),
    .en      (pre_en),
    .term    (prescale_q),
    .cnt     (pre_cnt_unused),
    .at_term (pre_term)
  );

  // Priority: stop > start > hold. stop/start also swallow any terminal tick.
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    prescale_d = prescale_q;
    mode_d     = mode_q;
    expire_d   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    pre_clr    = 1'b0;
    pre_en     = 1'b0;
    tick       = (state_q == ST_RUN) && !bus.hold && pre_term;

    if (bus.stop) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
      pre_clr = 1'b1;
    end else if (bus.start) begin
      state_d    = ST_RUN;
      period_d   = bus.period;
      prescale_d = bus.prescale;
      mode_d     = bus.mode;
      cnt_clr    = 1'b1;
      pre_clr    = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.hold) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            pre_clr = 1'b1;
            if (cnt_term) begin
              expire_d = 1'b1;
              if (mode_q == MODE_PERIODIC) cnt_clr = 1'b1;
              else                         state_d = ST_DONE;
            end else begin
              cnt_en = 1'b1;
            end
          end else begin
            pre_en = 1'b1;
          end
        end
        ST_PAUSE: if (!bus.hold) state_d = ST_RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      period_q   <= '0;
      prescale_q <= '0;
      mode_q     <= MODE_ONESHOT;
      expire_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      prescale_q <= prescale_d;
      mode_q     <= mode_d;
      expire_q   <= expire_d;
    end
  end

  assign bus.count  = count;
  assign bus.busy   = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.expire = expire_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: per-cycle expectations queued as stimulus
// is driven, then popped and checked one cycle after each rising edge.
module tb_timer_ctrl;
  localparam int WIDTH = 4;
  localparam int PRE_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  timer_ctrl_if #(.WIDTH(WIDTH), .PRE_W(PRE_W)) bus ();

  timer_ctrl #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [WIDTH+2:0] v;   // {count, busy, done, expire}
    string            tag;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   seq[6]   = '{0, 1, 1, 2, 2, 0};

  task automatic push(input int c, input bit b, input bit d, input bit e, input string tag);
    exp_t x;
    x.v   = {WIDTH'(c), b, d, e};
    x.tag = tag;
    q.push_back(x);
  endtask

  task automatic cyc();
    exp_t x;
    logic [WIDTH+2:0] obs;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      x   = q.pop_front();
      obs = {bus.count, bus.busy, bus.done, bus.expire};
      n_assert++;
      assert (obs === x.v) else begin
        n_fail++;
        $error("FAIL %s: observed count/busy/done/expire=%h/%b/%b/%b expected %h/%b/%b/%b",
               x.tag, obs[WIDTH+2:3], obs[2], obs[1], obs[0],
               x.v[WIDTH+2:3], x.v[2], x.v[1], x.v[0]);
      end
    end
  endtask

  task automatic cfg(input bit m, input int p, input int ps);
    bus.mode     = m;
    bus.period   = WIDTH'(p);
    bus.prescale = PRE_W'(ps);
  endtask

  initial begin
    bus.start = 0; bus.stop = 0; bus.hold = 0;
    cfg(0, 0, 0);

    // power-on reset
    push(0, 0, 0, 0, "rst0"); cyc();
    push(0, 0, 0, 0, "rst1"); cyc();
    rst = 0;

    // one-shot, period 3, prescale 0
    cfg(0, 3, 0); bus.start = 1;
    push(0, 1, 0, 0, "os_c0"); cyc();
    bus.start = 0; cfg(1, 15, 7);   // must be ignored after start
    push(1, 1, 0, 0, "os_c1"); cyc();
    push(2, 1, 0, 0, "os_c2"); cyc();
    push(3, 1, 0, 0, "os_c3"); cyc();
    push(3, 0, 1, 1, "os_done_exp"); cyc();
    push(3, 0, 1, 0, "os_done_hold0"); cyc();
    push(3, 0, 1, 0, "os_done_hold1"); cyc();
    bus.stop = 1;
    push(0, 0, 0, 0, "stop_from_done"); cyc();
    bus.stop = 0;

    // periodic, period 2, prescale 1
    cfg(1, 2, 1); bus.start = 1;
    push(0, 1, 0, 0, "per_start"); cyc();
    bus.start = 0;
    for (int i = 0; i < 12; i++) begin
      push(seq[i % 6], 1, 0, (i % 6) == 5, "per_seq"); cyc();
    end
    push(0, 1, 0, 0, "per_pre1"); cyc();
    push(1, 1, 0, 0, "per_c1a"); cyc();
    push(1, 1, 0, 0, "per_c1b"); cyc();   // prescaler now at 1

    // hold for 5 cycles with prescaler mid-phase
    bus.hold = 1;
    for (int i = 0; i < 5; i++) begin
      push(1, 1, 0, 0, "hold_frozen"); cyc();
    end
    bus.hold = 0;
    push(1, 1, 0, 0, "hold_release"); cyc();
    push(2, 1, 0, 0, "hold_phase_kept"); cyc();

    // restart at count 2
    bus.start = 1;
    push(0, 1, 0, 0, "restart"); cyc();
    bus.start = 0;
    push(0, 1, 0, 0, "rs_pre1"); cyc();
    push(1, 1, 0, 0, "rs_c1a"); cyc();
    push(1, 1, 0, 0, "rs_c1b"); cyc();
    push(2, 1, 0, 0, "rs_c2"); cyc();

    // stop at count 2
    bus.stop = 1;
    push(0, 0, 0, 0, "stop_run"); cyc();
    bus.stop = 0;
    push(0, 0, 0, 0, "idle_stays"); cyc();

    // start together with stop
    bus.start = 1; bus.stop = 1;
    push(0, 0, 0, 0, "start_stop"); cyc();
    bus.start = 0; bus.stop = 0;
    push(0, 0, 0, 0, "start_stop_idle"); cyc();

    // period 0 periodic: expire every cycle
    cfg(1, 0, 0); bus.start = 1;
    push(0, 1, 0, 0, "p0_start"); cyc();
    bus.start = 0;
    for (int i = 0; i < 4; i++) begin
      push(0, 1, 0, 1, "p0_expire"); cyc();
    end

    // start coincident with a terminal tick
    cfg(0, 3, 0); bus.start = 1;
    push(0, 1, 0, 0, "term_vs_start"); cyc();
    bus.start = 0;
    push(1, 1, 0, 0, "term_vs_start_c1"); cyc();

    // reset mid-run with an expire pending every cycle
    cfg(1, 0, 0); bus.start = 1;
    push(0, 1, 0, 0, "p0b_start"); cyc();
    bus.start = 0;
    push(0, 1, 0, 1, "p0b_exp0"); cyc();
    push(0, 1, 0, 1, "p0b_exp1"); cyc();
    rst = 1;
    push(0, 0, 0, 0, "midrst0"); cyc();
    push(0, 0, 0, 0, "midrst1"); cyc();
    rst = 0;
    push(0, 0, 0, 0, "after_rst"); cyc();

    // start with hold: start wins, then pause
    cfg(0, 3, 0); bus.start = 1; bus.hold = 1;
    push(0, 1, 0, 0, "start_hold"); cyc();
    bus.start = 0;
    push(0, 1, 0, 0, "sh_pause0"); cyc();
    push(0, 1, 0, 0, "sh_pause1"); cyc();
    bus.hold = 0;
    push(0, 1, 0, 0, "sh_release"); cyc();
    push(1, 1, 0, 0, "sh_count1"); cyc();

    n_assert++;
    assert (q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
